div_iter: RTL

Iterative 64-bit integer divider that returns quotient and remainder over a fixed multi-cycle latency. It is the inverse companion to the pipelined multiplier in the execute path and retires BITS_PER_CYCLE quotient bits per clock to hold the same clock period. It uses a start/done handshake toward the issuing stage and accepts one operation at a time.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 31 +++
 rtl/div_iter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider slice.
package div_pkg;

  localparam int DIV_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem,q} pair.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] q_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic [DIV_WIDTH-1:0] q_out
);

  logic [DIV_WIDTH:0]   rem_sh;
  logic [DIV_WIDTH+1:0] trial;
  logic                 unused_trial_hi;

  // Extra top bits carry the shifted-out remainder bit and the trial sign.
  assign rem_sh          = {rem_in, q_in[DIV_WIDTH-1]};
  assign trial           = {1'b0, rem_sh} - {2'b00, divisor};
  assign unused_trial_hi = trial[DIV_WIDTH];

  always_comb begin
    if (!trial[DIV_WIDTH+1]) begin
      rem_out = trial[DIV_WIDTH-1:0];
      q_out   = {q_in[DIV_WIDTH-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[DIV_WIDTH-1:0];
      q_out   = {q_in[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 64-bit divider, BITS_PER_CYCLE quotient bits per clock, start/done handshake.
// Define DIV_SIGNED_EN to build in signed division (sign fix-up on the final edge).
module div_iter
  import div_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 signed_op,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output div_state_t           state_dbg
);

  // Handshake: start is taken on any edge where busy=0; done pulses once per taken start.
  localparam int N  = DIV_WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t           state;
  logic [CW-1:0]        cnt;
  logic [DIV_WIDTH-1:0] rem_r, q_r, dvs_r, dvd_raw_r;
  logic                 zero_r;
  logic [DIV_WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin;

  logic [DIV_WIDTH-1:0] rem_c [0:BITS_PER_CYCLE];
  logic [DIV_WIDTH-1:0] q_c   [0:BITS_PER_CYCLE];

  assign state_dbg = state;
  assign rem_c[0]  = rem_r;
  assign q_c[0]    = q_r;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step u_step (
      .rem_in  (rem_c[i]),
      .q_in    (q_c[i]),
      .divisor (dvs_r),
      .rem_out (rem_c[i+1]),
      .q_out   (q_c[i+1])
    );
  end

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dvs_neg, neg_q_r, neg_r_r;
  assign dvd_neg = signed_op & dividend[DIV_WIDTH-1];
  assign dvs_neg = signed_op & divisor[DIV_WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // Divide-by-zero result overrides any sign correction.
  always_comb begin
    q_fin = q_c[BITS_PER_CYCLE];
    r_fin = rem_c[BITS_PER_CYCLE];
`ifdef DIV_SIGNED_EN
    if (neg_q_r) q_fin = -q_c[BITS_PER_CYCLE];
    if (neg_r_r) r_fin = -rem_c[BITS_PER_CYCLE];
`endif
    if (zero_r) begin
      q_fin = DIV_BY_ZERO_Q;
      r_fin = dvd_raw_r;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvs_r     <= '0;
      dvd_raw_r <= '0;
      zero_r    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem_r     <= '0;
            q_r       <= dvd_mag;
            dvs_r     <= dvs_mag;
            dvd_raw_r <= dividend;
            zero_r    <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_q_r   <= dvd_neg ^ dvs_neg;
            neg_r_r   <= dvd_neg;
`endif
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          rem_r <= rem_c[BITS_PER_CYCLE];
          q_r   <= q_c[BITS_PER_CYCLE];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            done      <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
